instr_fetch_buffer: RTL
=======================

Name: instr_fetch_buffer

Overview:
- Initiator side of the single-cycle instruction memory port: generates read requests (address, enable, write=0) and captures the combinationally returned 16-bit instruction words.
- Holds fetched words in a small prefetch FIFO tagged with their PC and presents them to decode over a valid/ready handshake.
- Handles redirects (branch/jump) and stops fetching after a HALT instruction.
- Sits between the PC/redirect logic and the decode stage.

Parameters:
- ADDR_WIDTH, 16, width of byte address and PC.
- BUF_DEPTH, 4, prefetch FIFO entries; power of 2, minimum 2.
- RESET_PC, 16'h0000, fetch address after reset (bit 0 must be 0).
- HALT_OPCODE, 5'b00000, value of instr[15:11] that stops fetching.

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous active-high reset
- imem_addr  out  ADDR_WIDTH  byte address to instruction memory; bit 0 always 0
- imem_enable  out  1  memory read enable
- imem_wr  out  1  memory write strobe; constant 0
- imem_data_in  out  16  memory write data; constant 0
- imem_data_out  in  16  instruction word returned combinationally by memory
- out_valid  out  1  FIFO head holds a valid instruction
- out_ready  in  1  decode accepts head this cycle
- out_instr  out  16  head instruction
- out_pc  out  ADDR_WIDTH  PC of head instruction
- out_pc_plus2  out  ADDR_WIDTH  out_pc + 2, modulo 2^ADDR_WIDTH
- redirect_valid  in  1  flush and restart fetch at redirect_pc
- redirect_pc  in  ADDR_WIDTH  new fetch address; bit 0 ignored (forced 0)
- halted  out  1  FSM in HALTED state

Behaviour:
- Reset (rst=1 at posedge):
  - fetch_pc=RESET_PC, count=0, rd/wr pointers=0, FSM=RUN.
  - While rst is high: imem_enable=0, out_valid=0, halted=0.
  - imem_wr=0 and imem_data_in=0 at all times.
  - A reset mid-operation discards all buffered entries and any pending halt.
- FSM states: RUN, HALTED.
  - RUN -> HALTED when an entry is pushed whose instr[15:11]==HALT_OPCODE and no redirect occurs that cycle.
  - HALTED -> RUN on redirect_valid.
  - HALTED is otherwise sticky until rst.
- Fetch condition: fetch_go = ~rst & (FSM==RUN) & (count<BUF_DEPTH) & ~redirect_valid.
  - imem_enable = fetch_go; imem_addr = fetch_pc.
  - Both are combinational from state and redirect_valid.
- Push: on posedge with fetch_go, write {fetch_pc, imem_data_out} at wr_ptr and set fetch_pc += 2 (wraps 0xFFFE -> 0x0000).
  - Throughput is one instruction per cycle; request-to-buffer latency is 1 edge.
  - The first instruction is visible on out_* the cycle after reset deasserts plus one edge.
- Full: count==BUF_DEPTH blocks fetch that cycle, even if a pop occurs in the same cycle (no full-bypass).
- Pop: on posedge with out_valid & out_ready & ~redirect_valid, advance rd_ptr.
- Simultaneous push and pop: count unchanged, both pointers advance.
- Output:
  - out_valid = (count!=0).
  - out_instr/out_pc come from the head entry; out_pc_plus2 = out_pc+2.
  - Values are don't-care when out_valid=0 but must not be X after reset.
- Redirect (redirect_valid=1 at posedge) takes priority over push, pop and halt:
  - count=0, pointers=0, fetch_pc={redirect_pc[AW-1:1],1'b0}, FSM=RUN.
  - No memory read in that cycle.
  - Next cycle fetches the redirect target.
- Empty: out_valid=0; out_ready is ignored.
- HALTED: no new fetches; buffered entries, including the HALT instruction, drain normally to decode.
- No write request is ever issued, so the memory's no-concurrent-read/write rule is always met.

Test Plan:
- Reset then run with out_ready=1, memory holding 0x1111,0x2222,0x3333 at 0,2,4 -> imem_addr 0,2,4 on consecutive cycles; out_instr 0x1111/pc 0, then 0x2222/pc 2, then 0x3333/pc 4, one per cycle.
- out_ready=0 for 10 cycles after reset -> exactly 4 fetches (addr 0..6), count=4, imem_enable=0 afterwards. Then out_ready=1 for one cycle -> pop of pc 0; next cycle fetch resumes at addr 8.
- Memory word at 0x0006 = 0x0000 (HALT), out_ready=1 -> fetches 0,2,4,6 only; halted=1 from the edge after addr 6; the HALT word is delivered with out_pc=6; out_valid=0 thereafter.
- With 3 entries buffered, redirect_valid=1 with redirect_pc=0x0041 and out_ready=1 in the same cycle -> next cycle out_valid=0, imem_addr=0x0040; following cycle out_pc=0x0040. No stale entry is ever presented.
- Redirect to 0xFFFE, out_ready=1 -> instructions delivered with pc 0xFFFE then 0x0000; out_pc_plus2 for 0xFFFE = 0x0000.
- Assert rst for one cycle while HALTED with 2 entries buffered -> out_valid=0, halted=0, imem_enable=0 during reset; after release, fetch restarts at RESET_PC.

Source files
------------

// File: rtl/instr_fetch_buffer.sv
// instr_fetch_buffer
//   Fetch-side initiator for a single-cycle instruction memory. It issues
//   read requests at the current fetch PC, captures the word the memory
//   returns in the same cycle, and queues {pc, instr} pairs in a small
//   prefetch FIFO that is offered to decode over a valid/ready handshake.
//   Redirects flush the FIFO and restart fetching. Pushing a HALT opcode
//   stops fetching until the next redirect or reset.
//
// Ports
//   clk, rst        : clock and synchronous active-high reset
//   imem_addr       : byte address of the read request (bit 0 always 0)
//   imem_enable     : read request strobe
//   imem_wr         : write strobe, tied to 0
//   imem_data_in    : write data, tied to 0
//   imem_data_out   : instruction word returned by memory this cycle
//   out_valid       : FIFO head holds an instruction
//   out_ready       : decode takes the head this cycle
//   out_instr       : head instruction word
//   out_pc          : PC of the head instruction
//   out_pc_plus2    : out_pc + 2 (wraps)
//   redirect_valid  : flush and restart fetch at redirect_pc
//   redirect_pc     : new fetch address (bit 0 forced to 0)
//   halted          : fetching stopped after a HALT instruction
module instr_fetch_buffer #(
  parameter int                    ADDR_WIDTH  = 16,
  parameter int                    BUF_DEPTH   = 4,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC    = '0,
  parameter logic [4:0]            HALT_OPCODE = 5'b00000
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  output logic                  imem_enable,
  output logic                  imem_wr,
  output logic [15:0]           imem_data_in,
  input  logic [15:0]           imem_data_out,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [15:0]           out_instr,
  output logic [ADDR_WIDTH-1:0] out_pc,
  output logic [ADDR_WIDTH-1:0] out_pc_plus2,
  input  logic                  redirect_valid,
  input  logic [ADDR_WIDTH-1:0] redirect_pc,
  output logic                  halted
);

  localparam int PTR_W = $clog2(BUF_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic {
    ST_RUN,
    ST_HALTED
  } state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] fetch_pc_q, fetch_pc_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [15:0]           buf_instr_q [BUF_DEPTH];
  logic [15:0]           buf_instr_d [BUF_DEPTH];
  logic [ADDR_WIDTH-1:0] buf_pc_q [BUF_DEPTH];
  logic [ADDR_WIDTH-1:0] buf_pc_d [BUF_DEPTH];

  logic fetch_go;
  logic pop_go;
  logic push_is_halt;

  // A full buffer blocks fetch even when a pop happens in the same cycle;
  // the freed slot is only refilled on the following cycle.
  assign fetch_go = ~rst & (state_q == ST_RUN) &
                    (count_q < CNT_W'(BUF_DEPTH)) & ~redirect_valid;

  // Outputs are masked during reset so a mid-operation reset hides the
  // stale buffer contents immediately rather than one edge later.
  assign out_valid    = ~rst & (count_q != '0);
  assign halted       = ~rst & (state_q == ST_HALTED);
  assign pop_go       = out_valid & out_ready & ~redirect_valid;
  assign push_is_halt = (imem_data_out[15:11] == HALT_OPCODE);

  assign imem_enable  = fetch_go;
  assign imem_addr    = fetch_pc_q;
  assign imem_wr      = 1'b0;
  assign imem_data_in = 16'h0000;

  assign out_instr    = buf_instr_q[rd_ptr_q];
  assign out_pc       = buf_pc_q[rd_ptr_q];
  assign out_pc_plus2 = out_pc + ADDR_WIDTH'(2);

  // Next-state logic. A redirect overrides push, pop and halt detection;
  // otherwise push and pop are independent and the count only moves when
  // exactly one of them happens.
  always_comb begin
    state_d     = state_q;
    fetch_pc_d  = fetch_pc_q;
    count_d     = count_q;
    rd_ptr_d    = rd_ptr_q;
    wr_ptr_d    = wr_ptr_q;
    buf_instr_d = buf_instr_q;
    buf_pc_d    = buf_pc_q;

    if (redirect_valid) begin
      state_d    = ST_RUN;
      count_d    = '0;
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
      fetch_pc_d = redirect_pc & {{(ADDR_WIDTH-1){1'b1}}, 1'b0};
    end else begin
      if (fetch_go) begin
        buf_instr_d[wr_ptr_q] = imem_data_out;
        buf_pc_d[wr_ptr_q]    = fetch_pc_q;
        wr_ptr_d              = wr_ptr_q + PTR_W'(1);
        fetch_pc_d            = fetch_pc_q + ADDR_WIDTH'(2);
        if (push_is_halt) begin
          state_d = ST_HALTED;
        end
      end
      if (pop_go) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      if (fetch_go && !pop_go) begin
        count_d = count_q + CNT_W'(1);
      end else if (!fetch_go && pop_go) begin
        count_d = count_q - CNT_W'(1);
      end
    end
  end

  // State register. Buffer storage is cleared on reset so the head outputs
  // are never unknown, even though they are don't-care while empty.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_RUN;
      fetch_pc_q <= RESET_PC;
      count_q    <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      for (int i = 0; i < BUF_DEPTH; i++) begin
        buf_instr_q[i] <= '0;
        buf_pc_q[i]    <= '0;
      end
    end else begin
      state_q     <= state_d;
      fetch_pc_q  <= fetch_pc_d;
      count_q     <= count_d;
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      buf_instr_q <= buf_instr_d;
      buf_pc_q    <= buf_pc_d;
    end
  end

endmodule
